seg7_sequence_checker: RTL and testbench

// - Receive-side monitor for the 3-bit state counter's 7-segment output. Sits on the

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_glyph_decoder.sv | 15 +
 rtl/seg7_sequence_checker.sv | 105 ++++++++++
 tb/tb_seg7_sequence_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants (active-low, bit0=a .. bit6=g) and the
// state-counter sequence rules used by the encoder and the receive-side checker.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;

  typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} seq_state_t;

  // Forward sequence of the producer: 0 1 3 5 7, with even values returning to 0.
  function automatic logic [2:0] next_fwd(input logic [2:0] v);
    logic [2:0] n;
    case (v)
      3'd0:    n = 3'd1;
      3'd1:    n = 3'd3;
      3'd3:    n = 3'd5;
      3'd5:    n = 3'd7;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] next_rev(input logic [2:0] v);
    return v - 3'd1;
  endfunction

  function automatic logic [2:0] glyph_to_val(input logic [6:0] g, output logic ok);
    logic [2:0] v;
    ok = 1'b1;
    case (g)
      GLYPH_0: v = 3'd0;
      GLYPH_1: v = 3'd1;
      GLYPH_2: v = 3'd2;
      GLYPH_3: v = 3'd3;
      GLYPH_4: v = 3'd4;
      GLYPH_5: v = 3'd5;
      GLYPH_6: v = 3'd6;
      GLYPH_7: v = 3'd7;
      default: begin
        v  = 3'd0;
        ok = 1'b0;
      end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational active-low glyph decoder: flags any pattern that is not 0..7.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] hex_in,
  output logic       ok,
  output logic [2:0] val
);

  always_comb begin
    ok  = 1'b0;
    val = glyph_to_val(hex_in, ok);
  end

endmodule

// File: rtl/seg7_sequence_checker.sv
// Receive-side monitor for the state counter's hex output: decodes each sampled
// glyph, tracks lock against the forward/reverse next-state rule, counts breaks.
module seg7_sequence_checker
  import seg7_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [6:0]       hex_in,
  input  logic             reverse,
  input  logic             load,
  output logic [2:0]       value,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic             bad_glyph,
  output logic [ERR_W-1:0] err_count
);

  seq_state_t state;
  logic [3:0] match_cnt;
  logic       dec_ok;
  logic [2:0] dec_val;
  logic [2:0] expected;
  logic       is_match;

  seg7_glyph_decoder u_dec (
    .hex_in (hex_in),
    .ok     (dec_ok),
    .val    (dec_val)
  );

  assign expected = reverse ? next_rev(value) : next_fwd(value);
  assign is_match = (dec_val == expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNSYNC;
      match_cnt <= 4'd0;
      value     <= 3'd0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      bad_glyph <= 1'b0;
      err_count <= '0;
    end else begin
      err       <= 1'b0;
      bad_glyph <= 1'b0;
      if (tick) begin
        if (!dec_ok) begin
          // Lost the glyph stream: drop lock, only an error if we were locked.
          bad_glyph <= 1'b1;
          valid     <= 1'b0;
          if (state == LOCKED) begin
            err <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
          state     <= UNSYNC;
          match_cnt <= 4'd0;
          locked    <= 1'b0;
        end else if (load) begin
          value <= dec_val;
          valid <= 1'b1;
        end else begin
          value <= dec_val;
          valid <= 1'b1;
          case (state)
            UNSYNC: begin
              match_cnt <= 4'd0;
              state     <= ACQUIRE;
            end
            ACQUIRE: begin
              if (is_match) begin
                match_cnt <= match_cnt + 4'd1;
                if (match_cnt == 4'(LOCK_N - 1)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= 4'd0;
              end
            end
            LOCKED: begin
              if (!is_match) begin
                err       <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
                locked    <= 1'b0;
                match_cnt <= 4'd0;
                state     <= ACQUIRE;
              end
            end
            default: begin
              match_cnt <= 4'd0;
              state     <= UNSYNC;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Directed bench for seg7_sequence_checker: default instance plus an ERR_W=2
// instance on the same stimulus to exercise counter saturation.
module tb_seg7_sequence_checker;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [6:0] hex_in = GLYPH_0;
  logic       reverse = 1'b0;
  logic       load = 1'b0;

  logic [2:0] value, value2;
  logic       valid, locked, err, bad_glyph;
  logic       valid2, locked2, err2, bad_glyph2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int vec = 0;
  int miss = 0;

  logic [6:0] g[8];

  always #5 clk = ~clk;

  seg7_sequence_checker #(.LOCK_N(3), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .hex_in(hex_in), .reverse(reverse),
    .load(load), .value(value), .valid(valid), .locked(locked), .err(err),
    .bad_glyph(bad_glyph), .err_count(err_count)
  );

  seg7_sequence_checker #(.LOCK_N(3), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .hex_in(hex_in), .reverse(reverse),
    .load(load), .value(value2), .valid(valid2), .locked(locked2), .err(err2),
    .bad_glyph(bad_glyph2), .err_count(err_count2)
  );

  // One tick on the next posedge; returns at the following negedge with outputs settled.
  task automatic do_tick(input logic [6:0] gl, input logic rev, input logic ld);
    @(negedge clk);
    hex_in = gl; reverse = rev; load = ld; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Outputs packed as {value, valid, locked, err, bad_glyph}.
  function automatic logic [6:0] obs();
    return {value, valid, locked, err, bad_glyph};
  endfunction

  task automatic test_reset();
    do_reset();
    vec++;
    if (obs() !== 7'b000_0000 || err_count !== 8'd0) begin
      $display("FAIL reset: got {v,vld,lk,err,bad}=%b cnt=%0d want 0000000 cnt=0", obs(), err_count);
      miss++;
    end
  endtask

  task automatic test_lock();
    logic [2:0] seq[4];
    logic [6:0] exp[4];
    seq = '{3'd0, 3'd1, 3'd3, 3'd5};
    exp = '{{3'd0, 4'b1000}, {3'd1, 4'b1000}, {3'd3, 4'b1000}, {3'd5, 4'b1100}};
    for (int i = 0; i < 4; i++) begin
      do_tick(g[seq[i]], 1'b0, 1'b0);
      vec++;
      if (obs() !== exp[i]) begin
        $display("FAIL lock[%0d]: got %b want %b", i, obs(), exp[i]);
        miss++;
      end
    end
  endtask

  task automatic test_no_tick();
    @(negedge clk);
    hex_in = GLYPH_2;
    repeat (2) @(negedge clk);
    vec++;
    if (obs() !== {3'd5, 4'b1100}) begin
      $display("FAIL no_tick_hold: got %b want %b", obs(), {3'd5, 4'b1100});
      miss++;
    end
  endtask

  task automatic test_break();
    do_tick(GLYPH_7, 1'b0, 1'b0);
    do_tick(GLYPH_0, 1'b0, 1'b0);
    vec++;
    if (obs() !== {3'd0, 4'b1100}) begin
      $display("FAIL break_pre: got %b want %b", obs(), {3'd0, 4'b1100});
      miss++;
    end
    do_tick(GLYPH_4, 1'b0, 1'b0);
    vec++;
    if (obs() !== {3'd4, 4'b1010} || err_count !== 8'd1) begin
      $display("FAIL break: got %b cnt=%0d want %b cnt=1", obs(), err_count, {3'd4, 4'b1010});
      miss++;
    end
    @(negedge clk);
    vec++;
    if (err !== 1'b0) begin
      $display("FAIL err_pulse_width: got err=%b want 0", err);
      miss++;
    end
  endtask

  task automatic test_reverse();
    // From ACQUIRE at 4: 7 is a silent mismatch, then 6,5,4 lock.
    do_tick(GLYPH_7, 1'b1, 1'b0);
    do_tick(GLYPH_6, 1'b1, 1'b0);
    do_tick(GLYPH_5, 1'b1, 1'b0);
    vec++;
    if (obs() !== {3'd5, 4'b1000} || err_count !== 8'd1) begin
      $display("FAIL rev_acquire: got %b cnt=%0d want %b cnt=1", obs(), err_count, {3'd5, 4'b1000});
      miss++;
    end
    do_tick(GLYPH_4, 1'b1, 1'b0);
    vec++;
    if (obs() !== {3'd4, 4'b1100}) begin
      $display("FAIL rev_lock: got %b want %b", obs(), {3'd4, 4'b1100});
      miss++;
    end
    do_tick(GLYPH_5, 1'b0, 1'b0);
    vec++;
    if (obs() !== {3'd5, 4'b1010} || err_count !== 8'd2) begin
      $display("FAIL rev_to_fwd: got %b cnt=%0d want %b cnt=2", obs(), err_count, {3'd5, 4'b1010});
      miss++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_tick(GLYPH_2, 1'b1, 1'b0);
    do_tick(GLYPH_1, 1'b1, 1'b0);
    do_tick(GLYPH_0, 1'b1, 1'b0);
    vec++;
    if (obs() !== {3'd0, 4'b1000}) begin
      $display("FAIL wrap_pre: got %b want %b", obs(), {3'd0, 4'b1000});
      miss++;
    end
    do_tick(GLYPH_7, 1'b1, 1'b0);
    vec++;
    if (obs() !== {3'd7, 4'b1100} || err_count !== 8'd0) begin
      $display("FAIL wrap: got %b cnt=%0d want %b cnt=0", obs(), err_count, {3'd7, 4'b1100});
      miss++;
    end
  endtask

  task automatic test_load();
    do_reset();
    do_tick(GLYPH_2, 1'b0, 1'b0);
    do_tick(GLYPH_0, 1'b0, 1'b0);
    do_tick(GLYPH_1, 1'b0, 1'b0);
    do_tick(GLYPH_3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(GLYPH_6, 1'b0, 1'b1);
      vec++;
      if (obs() !== {3'd6, 4'b1100}) begin
        $display("FAIL load[%0d]: got %b want %b", i, obs(), {3'd6, 4'b1100});
        miss++;
      end
    end
    do_tick(GLYPH_0, 1'b0, 1'b0);
    vec++;
    if (obs() !== {3'd0, 4'b1100} || err_count !== 8'd0) begin
      $display("FAIL load_release: got %b cnt=%0d want %b cnt=0", obs(), err_count, {3'd0, 4'b1100});
      miss++;
    end
  endtask

  task automatic test_bad_glyph();
    do_tick(7'b1111111, 1'b0, 1'b0);
    vec++;
    if (obs() !== {3'd0, 4'b0011} || err_count !== 8'd1) begin
      $display("FAIL bad_locked: got %b cnt=%0d want %b cnt=1", obs(), err_count, {3'd0, 4'b0011});
      miss++;
    end
    do_tick(GLYPH_2, 1'b0, 1'b0);
    vec++;
    if (obs() !== {3'd2, 4'b1000} || err_count !== 8'd1) begin
      $display("FAIL bad_resync: got %b cnt=%0d want %b cnt=1", obs(), err_count, {3'd2, 4'b1000});
      miss++;
    end
    // Bad glyph while not locked: flagged but not an error; load does not mask it.
    do_tick(7'b1111110, 1'b0, 1'b1);
    vec++;
    if (obs() !== {3'd2, 4'b0001} || err_count !== 8'd1) begin
      $display("FAIL bad_unlocked: got %b cnt=%0d want %b cnt=1", obs(), err_count, {3'd2, 4'b0001});
      miss++;
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_tick(GLYPH_0, 1'b0, 1'b0);
      do_tick(GLYPH_1, 1'b0, 1'b0);
      do_tick(GLYPH_3, 1'b0, 1'b0);
      do_tick(GLYPH_5, 1'b0, 1'b0);
      do_tick(7'b0000000, 1'b0, 1'b0);
      exp2 = (i >= 2) ? 2'd3 : 2'(i + 1);
      vec++;
      if (err2 !== 1'b1 || bad_glyph2 !== 1'b1 || err_count2 !== exp2) begin
        $display("FAIL sat[%0d]: got err=%b bad=%b cnt=%0d want err=1 bad=1 cnt=%0d",
                 i, err2, bad_glyph2, err_count2, exp2);
        miss++;
      end
      vec++;
      if (err_count !== 8'(i + 1)) begin
        $display("FAIL sat_wide[%0d]: got cnt=%0d want %0d", i, err_count, i + 1);
        miss++;
      end
    end
  endtask

  task automatic test_async_reset();
    do_tick(GLYPH_0, 1'b0, 1'b0);
    do_tick(GLYPH_1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    vec++;
    if (obs() !== 7'd0 || err_count !== 8'd0 || err_count2 !== 2'd0 ||
        {value2, valid2, locked2, err2, bad_glyph2} !== 7'd0) begin
      $display("FAIL async_reset: got %b cnt=%0d cnt2=%0d want all 0", obs(), err_count, err_count2);
      miss++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    g = '{GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7};
    test_reset();
    test_lock();
    test_no_tick();
    test_break();
    test_reverse();
    test_wrap();
    test_load();
    test_bad_glyph();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
